jtag_word_rx: RTL

TCK-domain JTAG deserialiser with an output word FIFO: a parametrised successor to the single-word BSCANE2 receiver. It assembles LSB-first TDI bits into WIDTH-bit words and buffers up to DEPTH words behind a valid/ready stream. It also reports overflow and fill level, and can optionally return flow-control status to the host on TDO. It sits directly behind the BSCANE2 primitive. The consumer side feeds the clock-domain-crossing FIFO into the core.

---
 rtl/jtag_word_rx_if.sv | 12 +
 rtl/jtag_word_rx.sv | 125 ++++++++++++
 2 files changed

// File: rtl/jtag_word_rx_if.sv
// jtag_word_rx_if: valid/ready word stream leaving the JTAG receiver.
// Ports: data/valid driven by master, ready driven by slave.
interface jtag_word_rx_if #(
   parameter int WIDTH = 8
) ();
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/jtag_word_rx.sv
// jtag_word_rx: TCK-domain deserialiser, LSB-first TDI -> WIDTH-bit words,
// buffered in a DEPTH-word FIFO behind a valid/ready stream (m).
// Ports: clk_i/rst_ni, BSCANE2 sel/capture/shift/tap_reset/tdi, tdo_o,
// m (master stream), level_o, overflow_o (sticky), word_cnt_o.
// Option: define JTAG_RX_STATUS_EN to return {overflow, free slots} on tdo_o.
module jtag_word_rx #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16,
   localparam int LW = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             sel_i,
   input  logic             capture_i,
   input  logic             shift_i,
   input  logic             tap_reset_i,
   input  logic             tdi_i,
   output logic             tdo_o,
   jtag_word_rx_if.master   m,
   output logic [LW-1:0]    level_o,
   output logic             overflow_o,
   output logic [CNT_W-1:0] word_cnt_o
);
   localparam int BW = $clog2(WIDTH);
   localparam int AW = $clog2(DEPTH);

   logic [BW-1:0]    bit_q;
   logic [WIDTH-1:0] sr_q;
   logic [AW-1:0]    wptr_q;
   logic [AW-1:0]    rptr_q;
   logic [LW-1:0]    level_q;
   logic [LW-1:0]    level_d;
   logic             ovf_q;
   logic             ovf_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             pop;
   logic             at_end;
   logic             push;
   logic             accept;
   logic [WIDTH-1:0] word;
   logic [WIDTH-1:0] reload;

   always_comb begin
      pop     = (level_q != '0) && m.ready;
      word    = {tdi_i, sr_q[WIDTH-1:1]};
      at_end  = (bit_q == BW'(WIDTH - 1));
      push    = sel_i && !capture_i && shift_i && at_end;
      // a pop on the same edge frees a slot, so a full FIFO still accepts
      accept  = push && ((level_q != LW'(DEPTH)) || pop);
      level_d = level_q;
      if (accept && !pop) begin
         level_d = level_q + LW'(1);
      end else if (pop && !accept) begin
         level_d = level_q - LW'(1);
      end
      ovf_d   = ovf_q || (push && !accept);
      reload  = '0;
`ifdef JTAG_RX_STATUS_EN
      // post-edge state, so the host sees the effect of this very word
      reload[LW-1:0]  = LW'(DEPTH) - level_d;
      reload[WIDTH-1] = ovf_d;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (accept && !tap_reset_i) begin
         mem_q[wptr_q] <= word;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bit_q   <= '0;
         sr_q    <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (tap_reset_i) begin
         bit_q   <= '0;
         sr_q    <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         if (pop) begin
            rptr_q <= rptr_q + AW'(1);
         end
         if (accept) begin
            wptr_q <= wptr_q + AW'(1);
            cnt_q  <= cnt_q + CNT_W'(1);
         end
         level_q <= level_d;
         ovf_q   <= ovf_d;
         if (!sel_i) begin
            bit_q <= '0;
            sr_q  <= '0;
         end else if (capture_i) begin
            bit_q <= '0;
            sr_q  <= reload;
         end else if (shift_i) begin
            if (at_end) begin
               bit_q <= '0;
               sr_q  <= reload;
            end else begin
               bit_q <= bit_q + BW'(1);
               sr_q  <= word;
            end
         end
      end
   end

   assign m.valid    = (level_q != '0);
   assign m.data     = m.valid ? mem_q[rptr_q] : '0;
   assign tdo_o      = sr_q[0];
   assign level_o    = level_q;
   assign overflow_o = ovf_q;
   assign word_cnt_o = cnt_q;
endmodule
